// File: rtl/magic_netlist_executor_if.sv
// magic_netlist_executor_if: instruction stream and result handshake bundle
interface magic_netlist_executor_if #(
  parameter int ADDR_W = 5,
  parameter int NUM_WIRES = 32
);
  logic ins_valid;
  logic ins_ready;
  logic [2+3*ADDR_W-1:0] ins_data;
  logic ins_last;
  logic out_valid;
  logic out_ready;
  logic [NUM_WIRES-1:0] out_state;
  modport master (
    output ins_valid, ins_data, ins_last, out_ready,
    input ins_ready, out_valid, out_state
  );
  modport slave (
    input ins_valid, ins_data, ins_last, out_ready,
    output ins_ready, out_valid, out_state
  );
endinterface

// File: rtl/magic_netlist_executor.sv
// magic_netlist_executor: MAGIC NOR/NOT netlist evaluator with explicit INIT/EVAL gate phases
module magic_netlist_executor #(
  parameter int NUM_IN = 5,
  parameter int ADDR_W = 5,
  parameter int NUM_WIRES = 32
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [NUM_IN-1:0] in_vec,
  magic_netlist_executor_if.slave bus,
  output logic err,
  output logic busy,
  output logic [15:0] cyc_count
);
  typedef enum logic [2:0] {IDLE, ACCEPT, INIT, EVAL, DONE} state_e;
  localparam logic [ADDR_W:0] LIM = NUM_WIRES[ADDR_W:0];
  state_e state_q, state_d;
  logic [NUM_WIRES-1:0] slots_q, slots_d;
  logic [2+3*ADDR_W-1:0] ins_q, ins_d;
  logic last_q, last_d;
  logic err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0] op, op_q;
  logic [ADDR_W-1:0] dst, sa, sb, dst_q, sa_q, sb_q;
  logic bad;
  assign {op, dst, sa, sb} = bus.ins_data;
  assign {op_q, dst_q, sa_q, sb_q} = ins_q;
  assign bad = op[1] | ({1'b0, dst} >= LIM) | ({1'b0, sa} >= LIM) | ({1'b0, sb} >= LIM)
             | (dst == sa) | (op[0] & (dst == sb));
  assign bus.ins_ready = state_q == ACCEPT;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_state = slots_q;
  assign err = err_q;
  assign busy = state_q != IDLE;
  assign cyc_count = cnt_q;
  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    ins_d = ins_q;
    last_d = last_q;
    err_d = err_q;
    cnt_d = (busy && state_q != DONE && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACCEPT;
        slots_d = '0;
        slots_d[NUM_IN-1:0] = in_vec;
        err_d = 1'b0;
        cnt_d = '0;
      end
      ACCEPT: if (bus.ins_valid) begin
        ins_d = bus.ins_data;
        last_d = bus.ins_last;
        err_d = err_q | bad;
        state_d = !bad ? INIT : bus.ins_last ? DONE : ACCEPT;
      end
      INIT: begin
        slots_d[dst_q] = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        slots_d[dst_q] = ~(slots_q[sa_q] | (op_q[0] & slots_q[sb_q]));
        state_d = last_q ? DONE : ACCEPT;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slots_q <= '0;
      ins_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      ins_q <= ins_d;
      last_q <= last_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_magic_netlist_executor.sv
// tb_magic_netlist_executor: directed self-checking bench for the MAGIC netlist executor
module tb_magic_netlist_executor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [4:0] in_vec = '0;
  logic err, busy;
  logic [15:0] cyc_count;
  int checks = 0;
  int failures = 0;
  logic [16:0] prog [13];
  magic_netlist_executor_if #(.ADDR_W(5), .NUM_WIRES(32)) bus ();
  magic_netlist_executor #(.NUM_IN(5), .ADDR_W(5), .NUM_WIRES(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_vec(in_vec),
    .bus(bus),
    .err(err),
    .busy(busy),
    .cyc_count(cyc_count)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] ins(input logic [1:0] op, input logic [4:0] d, a, b);
    return {op, d, a, b};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [16:0] d, input logic last, input int gap);
    int n = 0;
    while (!bus.ins_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_wait", {31'd0, bus.ins_ready}, 32'd1);
    repeat (gap) step();
    bus.ins_valid = 1'b1;
    bus.ins_data = d;
    bus.ins_last = last;
    step();
    bus.ins_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    chk("done_wait", {31'd0, bus.out_valid}, 32'd1);
  endtask
  task automatic begin_run(input logic [4:0] v);
    in_vec = v;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("rel_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rel_busy", {31'd0, busy}, 32'd0);
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.ins_ready}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_state"}, bus.out_state, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cyc"}, {16'd0, cyc_count}, 32'd0);
  endtask
  initial begin
    bus.ins_valid = 1'b0;
    bus.ins_data = '0;
    bus.ins_last = 1'b0;
    bus.out_ready = 1'b0;
    prog[0] = ins(2'b00, 5'd5, 5'd0, 5'd0);
    prog[1] = ins(2'b00, 5'd6, 5'd2, 5'd0);
    prog[2] = ins(2'b00, 5'd7, 5'd3, 5'd0);
    prog[3] = ins(2'b00, 5'd8, 5'd1, 5'd0);
    prog[4] = ins(2'b00, 5'd9, 5'd4, 5'd0);
    prog[5] = ins(2'b01, 5'd10, 5'd5, 5'd6);
    prog[6] = ins(2'b01, 5'd11, 5'd6, 5'd7);
    prog[7] = ins(2'b01, 5'd12, 5'd8, 5'd11);
    prog[8] = ins(2'b01, 5'd13, 5'd11, 5'd9);
    prog[9] = ins(2'b01, 5'd14, 5'd10, 5'd12);
    prog[10] = ins(2'b01, 5'd15, 5'd12, 5'd13);
    prog[11] = ins(2'b00, 5'd16, 5'd14, 5'd0);
    prog[12] = ins(2'b00, 5'd17, 5'd15, 5'd0);
    step();
    step();
    rst = 1'b0;
    check_reset_vals("reset");
    begin_run(5'b11111);
    chk("c17a_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 13; i++) send(prog[i], i == 12, 0);
    wait_done();
    chk("c17a_state", bus.out_state, 32'h0001_8C1F);
    chk("c17a_g22", {31'd0, bus.out_state[16]}, 32'd1);
    chk("c17a_g23", {31'd0, bus.out_state[17]}, 32'd0);
    chk("c17a_err", {31'd0, err}, 32'd0);
    chk("c17a_cyc", {16'd0, cyc_count}, 32'd39);
    release_result();
    begin_run(5'b00000);
    for (int i = 0; i < 13; i++) send(prog[i], i == 12, 0);
    wait_done();
    chk("c17b_state", bus.out_state, 32'h0000_C3E0);
    chk("c17b_cyc", {16'd0, cyc_count}, 32'd39);
    release_result();
    begin_run(5'b00001);
    send(ins(2'b00, 5'd5, 5'd0, 5'd0), 1'b1, 0);
    chk("not_init_ready", {31'd0, bus.ins_ready}, 32'd0);
    step();
    chk("not_init_slot5", {31'd0, dut.slots_q[5]}, 32'd1);
    chk("not_eval_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("not_done_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("not_done_state", bus.out_state, 32'h0000_0001);
    chk("not_cyc", {16'd0, cyc_count}, 32'd3);
    release_result();
    begin_run(5'b00000);
    send(ins(2'b01, 5'd7, 5'd7, 5'd1), 1'b0, 0);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_ready", {31'd0, bus.ins_ready}, 32'd1);
    chk("bad_slot7", {31'd0, bus.out_state[7]}, 32'd0);
    in_vec = 5'b11111;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("bad_start_ignored", {31'd0, err}, 32'd1);
    send(ins(2'b00, 5'd6, 5'd0, 5'd0), 1'b1, 0);
    wait_done();
    chk("bad_sticky", {31'd0, err}, 32'd1);
    chk("bad_state", bus.out_state, 32'h0000_0040);
    chk("bad_cyc", {16'd0, cyc_count}, 32'd5);
    release_result();
    begin_run(5'b00010);
    chk("gap_err_clr", {31'd0, err}, 32'd0);
    send(ins(2'b00, 5'd8, 5'd1, 5'd0), 1'b0, 4);
    send(ins(2'b01, 5'd9, 5'd8, 5'd0), 1'b1, 4);
    wait_done();
    chk("gap_cyc", {16'd0, cyc_count}, 32'd14);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_state", bus.out_state, 32'h0000_0202);
      step();
    end
    release_result();
    begin_run(5'b00000);
    send(ins(2'b10, 5'd3, 5'd1, 5'd2), 1'b1, 0);
    chk("ill_last_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("ill_last_err", {31'd0, err}, 32'd1);
    chk("ill_last_state", bus.out_state, 32'd0);
    chk("ill_last_cyc", {16'd0, cyc_count}, 32'd1);
    release_result();
    begin_run(5'b11111);
    send(ins(2'b00, 5'd5, 5'd0, 5'd0), 1'b0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("abort");
    step();
    chk("abort_no_pulse", {31'd0, bus.out_valid}, 32'd0);
    begin_run(5'b10101);
    send(ins(2'b11, 5'd1, 5'd2, 5'd3), 1'b1, 0);
    chk("reload_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("reload_state", bus.out_state, 32'h0000_0015);
    release_result();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/magic_netlist_executor.md
# magic_netlist_executor

Sequential evaluator for NOR/NOT-mapped netlists under MAGIC memristor semantics. It takes the primary-input vector for one run, then a stream of gate instructions matching the mapped netlists the flow emits (one `not` or `nor` per instruction). Each gate runs as an explicit INIT (output cell set to 1) and EVAL (conditional reset) pair. When the run ends, the block returns the full wire-slot state. It sits downstream of the NOR_NOT mapper as the consumer/executor of its output, used for netlist sign-off and cycle-count estimation.

## Interface
- NUM_IN, 5: primary inputs; loaded into slots 0..NUM_IN-1.
- ADDR_W, 5: slot address width.
- NUM_WIRES, 32: wire slots (memristor cells); must be ≤ 2^ADDR_W and > NUM_IN.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin run; sampled only in IDLE.
- in_vec  in  NUM_IN  primary-input values, captured with start.
- ins_valid  in  1  instruction valid.
- ins_ready  out  1  executor accepts instruction this cycle.
- ins_data  in  2+3*ADDR_W  {op[1:0], dst, srcA, srcB}; op 00 = NOT(srcA), 01 = NOR(srcA,srcB), 10/11 illegal.
- ins_last  in  1  marks final instruction of run.
- out_valid  out  1  run complete, result held.
- out_ready  in  1  result consumed.
- out_state  out  NUM_WIRES  slot contents at completion.
- err  out  1  sticky per run: illegal op, dst==srcA, dst==srcB (NOR only), or any address ≥ NUM_WIRES.
- busy  out  1  high in every state except IDLE.
- cyc_count  out  16  cycles from start acceptance to DONE entry, saturating at 0xFFFF.

## Operation
- States: IDLE, ACCEPT, INIT, EVAL, DONE.
- IDLE: ins_ready=0.
  - On start=1: slots[NUM_IN-1:0] <= in_vec, all other slots <= 0, err <= 0, cyc_count <= 0; go to ACCEPT.
- ACCEPT: ins_ready=1.
  - On ins_valid&ins_ready: latch op/dst/srcA/srcB/last.
  - If the instruction is illegal: set err, write no slot, skip INIT/EVAL. Go to DONE if last, otherwise stay in ACCEPT.
  - If legal: go to INIT.
- INIT: slot[dst] <= 1; go to EVAL.
- EVAL: slot[dst] <= 0 if slot[srcA] is 1, or (NOR) slot[srcB] is 1; otherwise slot[dst] stays 1. NOT ignores srcB. Go to DONE if latched last, otherwise to ACCEPT.
- DONE: out_valid=1, out_state = slots.
  - On out_ready: go to IDLE.
  - Slots are frozen while in DONE.
- Instructions may overwrite primary-input slots; this is legal and not an error.
- ins_valid outside ACCEPT is ignored; the source must hold it until ins_ready is high.
- start outside IDLE is ignored.

## Timing
- Reset values: ins_ready=0, out_valid=0, out_state=0, err=0, busy=0, cyc_count=0, all slots 0, state IDLE.
- rst mid-run aborts immediately. Next cycle matches the reset values; no out_valid pulse.
- Legal instruction: handshake cycle, then INIT, then EVAL. ins_ready is high again 3 cycles after the handshake, so peak throughput is 1 gate per 3 cycles.
- Illegal instruction: 1 cycle, ins_ready stays high.
- out_valid rises the cycle after the last EVAL (or after an illegal last handshake). It stays high until the out_ready cycle; out_valid&out_ready in the same cycle returns to IDLE next cycle.
- A new start is accepted in the first IDLE cycle after DONE.
- cyc_count increments every cycle in ACCEPT/INIT/EVAL, including ACCEPT cycles stalled on ins_valid=0.
- EVAL reads sources as they stood after the previous instruction's EVAL. The INIT write to dst is never visible as a source because dst≠src is enforced.

## Test plan
- c17 netlist, 13 instructions, in_vec slots 0..4 = {G1,G2,G3,G6,G7}, wires wr_3..wr_13 → slots 5..15, G22 → slot 16, G23 → slot 17:
  - in_vec=5'b11111 → slot16=1, slot17=0, err=0, cyc_count=39 with ins_valid held high.
  - in_vec=5'b00000 → slot16=0, slot17=0.
- Single NOT dst=5, srcA=0, in_vec bit0=1 → observe slot5=1 in INIT and slot5=0 after EVAL; out_valid 3 cycles after the handshake.
- NOR with dst=7, srcA=7 → err=1, slot7 unchanged at 0, ins_ready stays high. A following legal instruction executes normally and err stays 1 until the next start.
- ins_valid gapped 4 cycles between instructions, and out_ready held low 5 cycles → out_state stable and out_valid held throughout; cyc_count counts the gap cycles.
- rst asserted during an EVAL cycle → next cycle all outputs at reset values. A following start with in_vec=5'b10101 → slots 0..4 = 1,0,1,0,1, all others 0.
